float_to_fix_conv: RTL and testbench

- Iterative converter from half-precision float (1 sign / 5 exp, bias 15 / 10 mantissa) to signed two's-complement fix(8.8).
- Inverse of the Program 1 fix-to-float path. Sits beside the Program 2 core on the same byte-wide data memory and start/done testbench handshake.
- Reads the 16-bit float from memory, converts with one shift step per clock, writes the 16-bit fixed result back, then raises done.

---
 rtl/float_to_fix_conv.sv | 192 +++++++++++++++++++
 tb/tb_float_to_fix_conv.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_fix_conv.sv
// Iterative half-precision float to signed fix(8.8) converter.
// Reads the float from byte memory, shifts one bit per clock, writes the result back and raises done.
module float_to_fix_conv #(
  parameter logic [7:0] IN_ADDR    = 8'd4,
  parameter logic [7:0] OUT_ADDR   = 8'd6,
  parameter int         MAX_RSHIFT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  typedef enum logic [3:0] {
    IDLE, RD_HI, RD_LO, DECODE, SHIFT, NEG, WR_LO, WR_HI, DONE
  } state_t;

  localparam logic [4:0] MAX_RS5 = 5'(MAX_RSHIFT);

  state_t      state_reg, state_next;
  logic        done_reg, done_next;
  logic [7:0]  addr_reg, addr_next;
  logic        rd_en_reg, rd_en_next;
  logic        wr_en_reg, wr_en_next;
  logic [7:0]  wr_data_reg, wr_data_next;

  logic [7:0]  hi_reg;
  logic [15:0] mag_reg;
  logic [4:0]  cnt_reg;
  logic        left_reg;
  logic        sign_reg;
  logic        sat_reg;
  logic [15:0] result_reg;

  // Float word is assembled from the captured high byte and the low byte arriving now.
  logic [15:0] flt;
  logic        flt_s;
  logic [4:0]  flt_e;
  logic [9:0]  flt_m;
  assign flt   = {hi_reg, mem_rd_data};
  assign flt_s = flt[15];
  assign flt_e = flt[14:10];
  assign flt_m = flt[9:0];

  logic [15:0] dec_mag;
  logic [4:0]  dec_cnt;
  logic [4:0]  dec_rs;
  logic        dec_left;
  logic        dec_sat;

  always_comb begin
    dec_mag  = 16'd0;
    dec_cnt  = 5'd0;
    dec_rs   = 5'd0;
    dec_left = 1'b0;
    dec_sat  = 1'b0;
    if (flt_e == 5'd0) begin
      dec_mag = 16'd0;
    end else if (flt_e >= 5'd22) begin
      dec_sat = 1'b1;
    end else if (flt_e >= 5'd17) begin
      dec_mag  = {5'd0, 1'b1, flt_m};
      dec_left = 1'b1;
      dec_cnt  = flt_e - 5'd17;
    end else begin
      dec_mag = {5'd0, 1'b1, flt_m};
      dec_rs  = 5'd17 - flt_e;
      dec_cnt = (dec_rs >= MAX_RS5) ? MAX_RS5 : dec_rs;
    end
  end

  // Truncated negatives that reach magnitude 0 naturally negate to 0x0000.
  logic [15:0] result_comb;
  always_comb begin
    result_comb = mag_reg;
    if (sat_reg)
      result_comb = sign_reg ? 16'h8000 : 16'h7FFF;
    else if (sign_reg)
      result_comb = ~mag_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RD_HI;
      RD_HI:   state_next = RD_LO;
      RD_LO:   state_next = DECODE;
      DECODE:  state_next = (dec_cnt != 5'd0) ? SHIFT : NEG;
      SHIFT:   if (cnt_reg == 5'd1) state_next = NEG;
      NEG:     state_next = WR_LO;
      WR_LO:   state_next = WR_HI;
      WR_HI:   state_next = DONE;
      DONE:    if (start) state_next = RD_HI;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes and done are registered from the upcoming state so they align with it.
  always_comb begin
    addr_next    = addr_reg;
    rd_en_next   = 1'b0;
    wr_en_next   = 1'b0;
    wr_data_next = wr_data_reg;
    done_next    = 1'b0;
    case (state_next)
      RD_HI: begin
        addr_next  = IN_ADDR + 8'd1;
        rd_en_next = 1'b1;
      end
      RD_LO: begin
        addr_next  = IN_ADDR;
        rd_en_next = 1'b1;
      end
      WR_LO: begin
        addr_next    = OUT_ADDR;
        wr_en_next   = 1'b1;
        wr_data_next = result_comb[7:0];
      end
      WR_HI: begin
        addr_next    = OUT_ADDR + 8'd1;
        wr_en_next   = 1'b1;
        wr_data_next = result_reg[15:8];
      end
      DONE:    done_next = 1'b1;
      default: done_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_reg    <= 1'b0;
      addr_reg    <= 8'd0;
      rd_en_reg   <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= 8'd0;
    end else begin
      done_reg    <= done_next;
      addr_reg    <= addr_next;
      rd_en_reg   <= rd_en_next;
      wr_en_reg   <= wr_en_next;
      wr_data_reg <= wr_data_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg     <= 8'd0;
      mag_reg    <= 16'd0;
      cnt_reg    <= 5'd0;
      left_reg   <= 1'b0;
      sign_reg   <= 1'b0;
      sat_reg    <= 1'b0;
      result_reg <= 16'd0;
    end else begin
      case (state_reg)
        RD_LO: hi_reg <= mem_rd_data;
        DECODE: begin
          sign_reg <= flt_s;
          mag_reg  <= dec_mag;
          cnt_reg  <= dec_cnt;
          left_reg <= dec_left;
          sat_reg  <= dec_sat;
        end
        SHIFT: begin
          mag_reg <= left_reg ? (mag_reg << 1) : (mag_reg >> 1);
          cnt_reg <= cnt_reg - 5'd1;
        end
        NEG:     result_reg <= result_comb;
        default: result_reg <= result_reg;
      endcase
    end
  end

  assign done        = done_reg;
  assign mem_addr    = addr_reg;
  assign mem_rd_en   = rd_en_reg;
  assign mem_wr_en   = wr_en_reg;
  assign mem_wr_data = wr_data_reg;

endmodule

// File: tb/tb_float_to_fix_conv.sv
// Self-checking bench for float_to_fix_conv: byte-memory model plus a queue of expected results.
module tb_float_to_fix_conv;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rd_data = 8'h00;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  always #5 clk = ~clk;

  float_to_fix_conv dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  // Memory model: float input lives at bytes 4/5, result lands at bytes 6/7.
  logic [15:0] in_word = 16'h0000;
  logic [7:0]  out_lo = 8'h00;
  logic [7:0]  out_hi = 8'h00;
  int          wr_cnt = 0;
  bit          both_err = 1'b0;
  bit          addr_err = 1'b0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mem_addr == 8'd5)      mem_rd_data <= in_word[15:8];
      else if (mem_addr == 8'd4) mem_rd_data <= in_word[7:0];
      else begin
        mem_rd_data <= 8'h00;
        addr_err    <= 1'b1;
      end
    end
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr == 8'd6)      out_lo <= mem_wr_data;
      else if (mem_addr == 8'd7) out_hi <= mem_wr_data;
      else                       addr_err <= 1'b1;
    end
    if (mem_rd_en && mem_wr_en) both_err <= 1'b1;
  end

  typedef struct {
    logic [15:0] res;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [15:0] model(input logic [15:0] f, output int n);
    int e;
    int mant;
    int mag;
    e    = int'(f[14:10]);
    mant = int'({1'b1, f[9:0]});
    n    = 0;
    if (e == 0) return 16'h0000;
    if (e >= 22) return f[15] ? 16'h8000 : 16'h7FFF;
    if (e >= 17) begin
      n   = e - 17;
      mag = mant * (1 << n);
    end else begin
      mag = mant / (1 << (17 - e));
      n   = (17 - e > 12) ? 12 : 17 - e;
    end
    return f[15] ? 16'(-mag) : 16'(mag);
  endfunction

  task automatic push_exp(input logic [15:0] res, input int n);
    exp_t x;
    x.res = res;
    x.n   = n;
    sb.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic launch(input logic [15:0] f);
    in_word = f;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
    checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data: got %h expected 00", mem_wr_data); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL idle_done: got %b expected 0", done); end
  endtask

  task automatic test_vectors;
    logic [15:0] fv [9] = '{16'h3C00, 16'hBC00, 16'h57F8, 16'h1C00, 16'h1800,
                            16'h8000, 16'h5C00, 16'hD800, 16'h7C01};
    logic [15:0] rv [9] = '{16'h0100, 16'hFF00, 16'h7F80, 16'h0001, 16'h0000,
                            16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF};
    int          nv [9] = '{2, 2, 4, 10, 11, 0, 0, 0, 0};
    int   k, w0;
    exp_t x;
    for (int i = 0; i < 9; i++) begin
      w0 = wr_cnt;
      push_exp(rv[i], nv[i]);
      launch(fv[i]);
      wait_done(k);
      x = sb.pop_front();
      $display("vec in=%h result=%h latency=%0d", fv[i], {out_hi, out_lo}, k);
      checks++; if (k !== 6 + x.n) begin failures++; $display("FAIL vec_latency in=%h: got %0d expected %0d", fv[i], k, 6 + x.n); end
      checks++; if ({out_hi, out_lo} !== x.res) begin failures++; $display("FAIL vec_result in=%h: got %h expected %h", fv[i], {out_hi, out_lo}, x.res); end
      checks++; if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL vec_writes in=%h: got %0d expected 2", fv[i], wr_cnt - w0); end
    end
  endtask

  task automatic test_random;
    logic [15:0] f, r;
    int   n, k, w0;
    exp_t x;
    for (int i = 0; i < 16; i++) begin
      f = 16'($urandom);
      r = model(f, n);
      push_exp(r, n);
      w0 = wr_cnt;
      launch(f);
      wait_done(k);
      x = sb.pop_front();
      $display("rnd in=%h result=%h latency=%0d", f, {out_hi, out_lo}, k);
      checks++; if ({out_hi, out_lo} !== x.res || k !== 6 + x.n || wr_cnt - w0 !== 2) begin
        failures++;
        $display("FAIL rnd in=%h: got %h/%0d/%0d expected %h/%0d/2", f, {out_hi, out_lo}, k, wr_cnt - w0, x.res, 6 + x.n);
      end
    end
  endtask

  task automatic test_reset_abort;
    int   k, w0;
    exp_t x;
    w0 = wr_cnt;
    launch(16'h57F8);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL abort_outputs: got done=%b wr=%b rd=%b expected 0/0/0", done, mem_wr_en, mem_rd_en);
    end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL abort_addr: got %h expected 00", mem_addr); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (wr_cnt - w0 !== 0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_quiet: got writes=%0d done=%b expected 0/0", wr_cnt - w0, done);
    end
    push_exp(16'h0100, 2);
    launch(16'h3C00);
    wait_done(k);
    x = sb.pop_front();
    $display("after_abort in=3c00 result=%h latency=%0d", {out_hi, out_lo}, k);
    checks++; if ({out_hi, out_lo} !== x.res || k !== 6 + x.n) begin
      failures++; $display("FAIL abort_recover: got %h/%0d expected %h/%0d", {out_hi, out_lo}, k, x.res, 6 + x.n);
    end
  endtask

  task automatic test_busy_start;
    int   k, w0;
    exp_t x;
    w0 = wr_cnt;
    push_exp(16'h0001, 10);
    launch(16'h1C00);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    k = k + 6;
    x = sb.pop_front();
    $display("busy_start in=1c00 result=%h latency=%0d", {out_hi, out_lo}, k);
    checks++; if (k !== 6 + x.n) begin failures++; $display("FAIL busy_latency: got %0d expected %0d", k, 6 + x.n); end
    checks++; if ({out_hi, out_lo} !== x.res) begin failures++; $display("FAIL busy_result: got %h expected %h", {out_hi, out_lo}, x.res); end
    repeat (10) @(negedge clk);
    checks++; if (done !== 1'b1 || wr_cnt - w0 !== 2) begin
      failures++; $display("FAIL busy_ignored: got done=%b writes=%0d expected 1/2", done, wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back;
    int   k, w0;
    exp_t x;
    w0 = wr_cnt;
    push_exp(16'h7F80, 4);
    push_exp(16'hFF00, 2);
    in_word = 16'h57F8;
    start   = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_drop1: got %b expected 0", done); end
    repeat (3) @(negedge clk);
    in_word = 16'hBC00;
    wait_done(k);
    k = k + 3;
    x = sb.pop_front();
    $display("b2b1 in=57f8 result=%h latency=%0d", {out_hi, out_lo}, k);
    checks++; if ({out_hi, out_lo} !== x.res || k !== 6 + x.n || wr_cnt - w0 !== 2) begin
      failures++; $display("FAIL b2b_first: got %h/%0d/%0d expected %h/%0d/2", {out_hi, out_lo}, k, wr_cnt - w0, x.res, 6 + x.n);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_drop2: got %b expected 0", done); end
    wait_done(k);
    start = 1'b0;
    x = sb.pop_front();
    $display("b2b2 in=bc00 result=%h latency=%0d", {out_hi, out_lo}, k);
    checks++; if ({out_hi, out_lo} !== x.res || k !== 6 + x.n || wr_cnt - w0 !== 4) begin
      failures++; $display("FAIL b2b_second: got %h/%0d/%0d expected %h/%0d/4", {out_hi, out_lo}, k, wr_cnt - w0, x.res, 6 + x.n);
    end
    repeat (4) @(negedge clk);
    checks++; if (done !== 1'b1 || wr_cnt - w0 !== 4) begin
      failures++; $display("FAIL b2b_stop: got done=%b writes=%0d expected 1/4", done, wr_cnt - w0);
    end
  endtask

  task automatic test_bus_rules;
    checks++; if (both_err !== 1'b0) begin failures++; $display("FAIL bus_rd_wr_overlap: got %b expected 0", both_err); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL bus_address: got %b expected 0", addr_err); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_vectors;
    test_random;
    test_reset_abort;
    test_busy_start;
    test_back_to_back;
    test_bus_rules;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
